// File: rtl/cache_write_buffer.sv
// cache_write_buffer: posted-write buffer between the cache memory-side port
// and main memory. Cache writes are queued in a DEPTH-entry FIFO and acked
// at once; the FIFO drains to memory in the background. Reads go to memory,
// or are answered from the youngest matching buffered write so memory never
// returns stale data.
//
// Configuration macro: WB_FORWARD_EN
//   defined   : read hits are answered directly from the buffer
//   undefined : read hits wait in RD_STALL until no buffered entry matches,
//               then go to memory (no forwarding mux is built)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cache_req_val/rdy/msg           request from cache (mem_req_4B_t)
//   cache_resp_val/rdy/msg          response to cache (mem_resp_4B_t)
//   mem_req_val/rdy/msg             request to memory (mem_req_4B_t)
//   mem_resp_val/rdy/msg            response from memory (mem_resp_4B_t)
//   drain                           level request to empty the buffer
//   drain_done                      one-cycle pulse once drain is satisfied

package mem_msg_pkg;
   localparam logic [3:0] MEM_READ  = 4'd0;
   localparam logic [3:0] MEM_WRITE = 4'd1;

   typedef struct packed {
      logic [3:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [3:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;
endpackage

module cache_write_buffer
   import mem_msg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cache_req_val,
   output logic         cache_req_rdy,
   input  mem_req_4B_t  cache_req_msg,
   output logic         cache_resp_val,
   input  logic         cache_resp_rdy,
   output mem_resp_4B_t cache_resp_msg,
   output logic         mem_req_val,
   input  logic         mem_req_rdy,
   output mem_req_4B_t  mem_req_msg,
   input  logic         mem_resp_val,
   output logic         mem_resp_rdy,
   input  mem_resp_4B_t mem_resp_msg,
   input  logic         drain,
   output logic         drain_done
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      RESP     = 3'd3
`ifndef WB_FORWARD_EN
      , RD_STALL = 3'd4
`endif
   } state_t;

   state_t        state_r, state_next_s;
   logic [31:0]   addr_q_r [DEPTH];
   logic [31:0]   data_q_r [DEPTH];
   logic [PW-1:0] head_r, tail_r;
   logic [PW:0]   count_r, count_next_s;
   mem_req_4B_t   rd_req_r;
   mem_resp_4B_t  resp_r;
   logic          drain_done_r, armed_r;

   logic          req_is_write_s, full_s, req_acc_s, enq_s, pop_s, hit_s;
   logic [29:0]   cmp_addr_s;
`ifdef WB_FORWARD_EN
   logic [31:0]   hit_data_s;
`endif

   // Length and test fields are fixed to zero for word accesses.
   logic unused_fields_s;
   assign unused_fields_s = ^{cache_req_msg.len, mem_resp_msg.test, mem_resp_msg.len};

   assign req_is_write_s = (cache_req_msg.type_ == MEM_WRITE);
   assign full_s         = (count_r == FULL_CNT);
   assign cache_req_rdy  = (state_r == IDLE) && !(req_is_write_s && full_s);
   assign req_acc_s      = cache_req_val && cache_req_rdy;
   assign enq_s          = req_acc_s && req_is_write_s;
   // A read waiting in RD_ISSUE owns the memory port.
   assign pop_s          = (count_r != (PW+1)'(0)) && (state_r != RD_ISSUE) && mem_req_rdy;
   assign count_next_s   = count_r + (PW+1)'(enq_s) - (PW+1)'(pop_s);

   assign cache_resp_val = (state_r == RESP);
   assign cache_resp_msg = resp_r;
   assign mem_req_val    = (state_r == RD_ISSUE) || (count_r != (PW+1)'(0));
   assign mem_resp_rdy   = 1'b1;
   assign drain_done     = drain_done_r;

   // Address match against every valid entry, oldest to youngest, so the
   // last match recorded is the youngest one.
   always_comb begin
      hit_s = 1'b0;
`ifdef WB_FORWARD_EN
      hit_data_s = 32'd0;
      cmp_addr_s = cache_req_msg.addr[31:2];
`else
      if (state_r == RD_STALL) begin
         cmp_addr_s = rd_req_r.addr[31:2];
      end else begin
         cmp_addr_s = cache_req_msg.addr[31:2];
      end
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if (((PW+1)'(i) < count_r) && (addr_q_r[head_r + PW'(i)][31:2] == cmp_addr_s)) begin
            hit_s = 1'b1;
`ifdef WB_FORWARD_EN
            hit_data_s = data_q_r[head_r + PW'(i)];
`endif
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Next-state logic of the request FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_acc_s) begin
               if (req_is_write_s) begin
                  state_next_s = RESP;
               end else if (hit_s) begin
`ifdef WB_FORWARD_EN
                  state_next_s = RESP;
`else
                  state_next_s = RD_STALL;
`endif
               end else begin
                  state_next_s = RD_ISSUE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         RD_ISSUE: begin
            if (mem_req_rdy) state_next_s = RD_WAIT;
            else             state_next_s = RD_ISSUE;
         end
         RD_WAIT: begin
            if (mem_resp_val && (mem_resp_msg.type_ == MEM_READ)) state_next_s = RESP;
            else                                                  state_next_s = RD_WAIT;
         end
         RESP: begin
            if (cache_resp_rdy) state_next_s = IDLE;
            else                state_next_s = RESP;
         end
`ifndef WB_FORWARD_EN
         RD_STALL: begin
            if (!hit_s) state_next_s = RD_ISSUE;
            else        state_next_s = RD_STALL;
         end
`endif
         default: state_next_s = IDLE;
      endcase
   end

   // Memory request mux: latched read in RD_ISSUE, otherwise the FIFO head.
   always_comb begin
      mem_req_msg = '0;
      if (state_r == RD_ISSUE) begin
         mem_req_msg = rd_req_r;
      end else if (count_r != (PW+1)'(0)) begin
         mem_req_msg = '{MEM_WRITE, 8'd0, addr_q_r[head_r], 2'd0, data_q_r[head_r]};
      end else begin
         mem_req_msg = '0;
      end
   end

   // FIFO storage, written on enqueue only.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         addr_q_r[tail_r] <= cache_req_msg.addr;
         data_q_r[tail_r] <= cache_req_msg.data;
      end
   end

   // State, FIFO pointers, response register and drain handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         head_r       <= '0;
         tail_r       <= '0;
         count_r      <= '0;
         rd_req_r     <= '0;
         resp_r       <= '0;
         drain_done_r <= 1'b0;
         armed_r      <= 1'b1;
      end else begin
         state_r <= state_next_s;
         count_r <= count_next_s;
         if (enq_s) tail_r <= tail_r + PW'(1);
         if (pop_s) head_r <= head_r + PW'(1);

         if (req_acc_s && req_is_write_s) begin
            resp_r <= '{MEM_WRITE, cache_req_msg.opaque, 2'd0, 2'd0, 32'd0};
         end else if (req_acc_s) begin
            rd_req_r <= '{MEM_READ, cache_req_msg.opaque, cache_req_msg.addr, 2'd0, 32'd0};
`ifdef WB_FORWARD_EN
            if (hit_s) resp_r <= '{MEM_READ, cache_req_msg.opaque, 2'd0, 2'd0, hit_data_s};
`endif
         end else if ((state_r == RD_WAIT) && mem_resp_val && (mem_resp_msg.type_ == MEM_READ)) begin
            resp_r <= '{MEM_READ, mem_resp_msg.opaque, 2'd0, 2'd0, mem_resp_msg.data};
         end

         // Pulse registered on the count about to become zero, so it shows
         // in the first cycle the buffer is empty; re-arm when drain drops.
         drain_done_r <= drain && armed_r && (count_next_s == (PW+1)'(0));
         if (!drain) begin
            armed_r <= 1'b1;
         end else if (count_next_s == (PW+1)'(0)) begin
            armed_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed testbench for cache_write_buffer with a small memory model.
module tb_cache_write_buffer;
   import mem_msg_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cache_req_val = 1'b0;
   logic         cache_req_rdy;
   mem_req_4B_t  cache_req_msg = '0;
   logic         cache_resp_val;
   logic         cache_resp_rdy = 1'b1;
   mem_resp_4B_t cache_resp_msg;
   logic         mem_req_val;
   logic         mem_req_rdy = 1'b1;
   mem_req_4B_t  mem_req_msg;
   logic         mem_resp_val = 1'b0;
   logic         mem_resp_rdy;
   mem_resp_4B_t mem_resp_msg = '0;
   logic         drain = 1'b0;
   logic         drain_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   cache_write_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy), .cache_req_msg(cache_req_msg),
      .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy), .cache_resp_msg(cache_resp_msg),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
      .drain(drain), .drain_done(drain_done)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   typedef struct {
      logic [3:0]  t;
      logic [31:0] addr;
      logic [31:0] data;
   } log_t;

   logic [31:0] mem [logic [31:0]];
   log_t        mlog [$];
   int          rd_cnt = 0;
   int          rd_lat = 1;
   logic [31:0] rd_data = 32'd0;
   logic [7:0]  rd_opq = 8'd0;
   bit          wr_resp_pending = 1'b0;
   logic [31:0] key;
   int          mresp_c = -1;

   always @(posedge clk) begin
      mem_resp_val <= 1'b0;
      if (rd_cnt == 1) begin
         mem_resp_val <= 1'b1;
         mem_resp_msg <= '{MEM_READ, rd_opq, 2'd0, 2'd0, rd_data};
      end else if (wr_resp_pending) begin
         mem_resp_val <= 1'b1;
         mem_resp_msg <= '{MEM_WRITE, 8'd0, 2'd0, 2'd0, 32'd0};
      end
      if (rd_cnt > 0) rd_cnt = rd_cnt - 1;
      wr_resp_pending = 1'b0;
      if (mem_req_val && mem_req_rdy) begin
         mlog.push_back('{mem_req_msg.type_, mem_req_msg.addr, mem_req_msg.data});
         key = {mem_req_msg.addr[31:2], 2'b00};
         if (mem_req_msg.type_ == MEM_WRITE) begin
            mem[key] = mem_req_msg.data;
            wr_resp_pending = 1'b1;
         end else begin
            rd_data = mem.exists(key) ? mem[key] : 32'd0;
            rd_opq  = mem_req_msg.opaque;
            rd_cnt  = rd_lat;
         end
      end
   end

   always @(negedge clk) begin
      if (mem_resp_val && (mem_resp_msg.type_ == MEM_READ)) mresp_c = cyc;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One cache transaction; returns response, accept/response cycles and
   // the memory port as seen in the cycle after acceptance.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [7:0] opq, output mem_resp_4B_t resp, output int acc_c,
                      output int resp_c, output logic mv_n1, output mem_req_4B_t mm_n1);
      int n;
      resp = '0; mv_n1 = 1'b0; mm_n1 = '0;
      @(posedge clk); #1;
      cache_req_val = 1'b1;
      cache_req_msg = '{wr ? MEM_WRITE : MEM_READ, opq, addr, 2'd0, wr ? data : 32'd0};
      acc_c = -1; n = 0;
      while (acc_c < 0 && n < 200) begin
         @(negedge clk);
         if (cache_req_rdy) acc_c = cyc;
         n++;
      end
      if (acc_c < 0) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got no cache_req_rdy expected accept within 200 cycles");
      end
      @(posedge clk); #1;
      cache_req_val = 1'b0;
      resp_c = -1; n = 0;
      while (resp_c < 0 && n < 200) begin
         @(negedge clk);
         if (n == 0) begin
            mv_n1 = mem_req_val;
            mm_n1 = mem_req_msg;
         end
         if (cache_resp_val) begin
            resp = cache_resp_msg;
            resp_c = cyc;
         end
         n++;
      end
      if (resp_c < 0) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got no cache_resp_val expected response within 200 cycles");
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  opq;
      logic [3:0]  etype;
      logic [31:0] edata;
   } vec_t;

   vec_t         vecs [7];
   mem_resp_4B_t r;
   int           ac, rc, pulses, pulse_c, last_pop, base_c, saw, lsz;
   logic         mv;
   mem_req_4B_t  mm;

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0100, 32'hA5A5_0001, 8'h01, MEM_WRITE, 32'd0};
      vecs[1] = '{1'b0, 32'h0000_0200, 32'd0,         8'h02, MEM_READ,  32'h0BAD_F00D};
      vecs[2] = '{1'b1, 32'h0000_0104, 32'h1111_2222, 8'h03, MEM_WRITE, 32'd0};
      vecs[3] = '{1'b0, 32'h0000_0104, 32'd0,         8'h04, MEM_READ,  32'h1111_2222};
      vecs[4] = '{1'b0, 32'h0000_0100, 32'd0,         8'h05, MEM_READ,  32'hA5A5_0001};
      vecs[5] = '{1'b1, 32'h0000_0104, 32'h3333_4444, 8'h06, MEM_WRITE, 32'd0};
      vecs[6] = '{1'b0, 32'h0000_0106, 32'd0,         8'h07, MEM_READ,  32'h3333_4444};
      mem[32'h0000_0200] = 32'h0BAD_F00D;
      mem[32'h0000_0080] = 32'h0000_1234;

      // reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_cache_req_rdy", {31'd0, cache_req_rdy}, 32'd1);
      check("rst_cache_resp_val", {31'd0, cache_resp_val}, 32'd0);
      check("rst_mem_req_val", {31'd0, mem_req_val}, 32'd0);
      check("rst_mem_resp_rdy", {31'd0, mem_resp_rdy}, 32'd1);
      check("rst_drain_done", {31'd0, drain_done}, 32'd0);
      check("rst_resp_msg", cache_resp_msg[31:0], 32'd0);

      // write ack and first drain, WRITE response dropped
      mlog.delete();
      txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 8'h11, r, ac, rc, mv, mm);
      check("wack_type", {28'd0, r.type_}, {28'd0, MEM_WRITE});
      check("wack_data", r.data, 32'd0);
      check("wack_opaque", {24'd0, r.opaque}, 32'h11);
      check("wack_latency", rc - ac, 32'd1);
      check("drain1_val", {31'd0, mv}, 32'd1);
      check("drain1_type", {28'd0, mm.type_}, {28'd0, MEM_WRITE});
      check("drain1_addr", mm.addr, 32'h0000_1000);
      check("drain1_data", mm.data, 32'hDEAD_BEEF);
      saw = 0;
      repeat (6) begin
         @(negedge clk);
         if (cache_resp_val) saw++;
      end
      check("wresp_dropped", saw, 32'd0);
      check("mem_got_write", mem[32'h0000_1000], 32'hDEAD_BEEF);

      // table-driven vectors with memory always ready
      for (int i = 0; i < 7; i++) begin
         txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].opq, r, ac, rc, mv, mm);
         check($sformatf("vec%0d_type", i), {28'd0, r.type_}, {28'd0, vecs[i].etype});
         check($sformatf("vec%0d_data", i), r.data, vecs[i].edata);
         check($sformatf("vec%0d_opaque", i), {24'd0, r.opaque}, {24'd0, vecs[i].opq});
         if (vecs[i].wr) check($sformatf("vec%0d_wlat", i), rc - ac, 32'd1);
      end

      // full buffer: 4 acks, 5th write stalled until a pop
      repeat (4) @(posedge clk);
      #1 mem_req_rdy = 1'b0;
      mlog.delete();
      for (int i = 0; i < 4; i++) begin
         txn(1'b1, 32'h10 + 32'(4 * i), 32'hC0 + 32'(i), 8'(i), r, ac, rc, mv, mm);
         check($sformatf("full_ack%0d", i), {28'd0, r.type_}, {28'd0, MEM_WRITE});
      end
      @(posedge clk); #1;
      cache_req_val = 1'b1;
      cache_req_msg = '{MEM_WRITE, 8'h04, 32'h20, 2'd0, 32'hC4};
      saw = 0;
      repeat (3) begin
         @(negedge clk);
         if (cache_req_rdy) saw++;
      end
      check("full_rdy_low", saw, 32'd0);
      @(posedge clk); #1 mem_req_rdy = 1'b1;
      @(negedge clk);
      check("full_rdy_prepop", {31'd0, cache_req_rdy}, 32'd0);
      @(negedge clk);
      check("full_rdy_afterpop", {31'd0, cache_req_rdy}, 32'd1);
      @(posedge clk); #1 cache_req_val = 1'b0;
      @(negedge clk);
      check("full_ack5_val", {31'd0, cache_resp_val}, 32'd1);
      check("full_ack5_type", {28'd0, cache_resp_msg.type_}, {28'd0, MEM_WRITE});
      repeat (8) @(posedge clk);
      check("full_drain_cnt", mlog.size(), 32'd5);
      for (int i = 0; i < 5 && i < mlog.size(); i++) begin
         check($sformatf("full_order_addr%0d", i), mlog[i].addr, 32'h10 + 32'(4 * i));
         check($sformatf("full_order_data%0d", i), mlog[i].data, 32'hC0 + 32'(i));
      end

      // read of a word still buffered twice
      #1 mem_req_rdy = 1'b0;
      mlog.delete();
      txn(1'b1, 32'h40, 32'd1, 8'h21, r, ac, rc, mv, mm);
      txn(1'b1, 32'h40, 32'd2, 8'h22, r, ac, rc, mv, mm);
      fork
         begin
            txn(1'b0, 32'h40, 32'd0, 8'h23, r, ac, rc, mv, mm);
            lsz = mlog.size();
         end
         begin
            repeat (8) @(posedge clk);
            #1 mem_req_rdy = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      check("fwd_type", {28'd0, r.type_}, {28'd0, MEM_READ});
      check("fwd_data", r.data, 32'd2);
      check("fwd_opaque", {24'd0, r.opaque}, 32'h23);
`ifdef WB_FORWARD_EN
      check("fwd_latency", rc - ac, 32'd1);
      check("fwd_no_mem_before", lsz, 32'd0);
      check("fwd_log_size", mlog.size(), 32'd2);
`else
      check("stall_log_size", mlog.size(), 32'd3);
      if (mlog.size() == 3) begin
         check("stall_first_w", mlog[0].data, 32'd1);
         check("stall_second_w", mlog[1].data, 32'd2);
         check("stall_read_last", {28'd0, mlog[2].t}, {28'd0, MEM_READ});
      end
`endif

      // read miss with two writes pending: read overtakes the second drain
      #1 mem_req_rdy = 1'b0;
      rd_lat = 3;
      mlog.delete();
      txn(1'b1, 32'h500, 32'd5, 8'h31, r, ac, rc, mv, mm);
      txn(1'b1, 32'h504, 32'd6, 8'h32, r, ac, rc, mv, mm);
      fork
         begin
            @(posedge clk);
            #1 mem_req_rdy = 1'b1;
         end
         txn(1'b0, 32'h80, 32'd0, 8'h5A, r, ac, rc, mv, mm);
      join
      check("miss_type", {28'd0, r.type_}, {28'd0, MEM_READ});
      check("miss_data", r.data, 32'h0000_1234);
      check("miss_opaque", {24'd0, r.opaque}, 32'h5A);
      check("miss_resp_after_mem", rc - mresp_c, 32'd1);
      check("miss_issue_n1", {31'd0, mv && (mm.type_ == MEM_READ)}, 32'd1);
      repeat (4) @(posedge clk);
      check("miss_log_size", mlog.size(), 32'd3);
      if (mlog.size() == 3) begin
         check("miss_order0", mlog[0].addr, 32'h500);
         check("miss_order1", mlog[1].addr, 32'h80);
         check("miss_order2", mlog[2].addr, 32'h504);
      end

      // reset while a read waits in RD_WAIT with 3 writes buffered
      #1 mem_req_rdy = 1'b0;
      rd_lat = 8;
      txn(1'b1, 32'h600, 32'd7, 8'h41, r, ac, rc, mv, mm);
      txn(1'b1, 32'h604, 32'd8, 8'h42, r, ac, rc, mv, mm);
      txn(1'b1, 32'h608, 32'd9, 8'h43, r, ac, rc, mv, mm);
      @(posedge clk); #1;
      cache_req_val = 1'b1;
      cache_req_msg = '{MEM_READ, 8'h77, 32'h84, 2'd0, 32'd0};
      @(negedge clk);
      check("rst_seq_rd_rdy", {31'd0, cache_req_rdy}, 32'd1);
      @(posedge clk); #1;
      cache_req_val = 1'b0;
      mem_req_rdy = 1'b1;
      @(negedge clk);
      check("rst_seq_issue", {31'd0, mem_req_val && (mem_req_msg.type_ == MEM_READ)}, 32'd1);
      @(posedge clk); #1;
      mem_req_rdy = 1'b0;
      reset = 1'b1;
      base_c = mresp_c;
      @(posedge clk); #1;
      reset = 1'b0;
      mlog.delete();
      @(negedge clk);
      check("rst_seq_req_rdy", {31'd0, cache_req_rdy}, 32'd1);
      check("rst_seq_mem_val", {31'd0, mem_req_val}, 32'd0);
      check("rst_seq_resp_val", {31'd0, cache_resp_val}, 32'd0);
      mem_req_rdy = 1'b1;
      saw = 0;
      repeat (12) begin
         @(negedge clk);
         if (cache_resp_val) saw++;
      end
      check("rst_seq_late_resp_seen", {31'd0, mresp_c > base_c}, 32'd1);
      check("rst_seq_late_dropped", saw, 32'd0);
      check("rst_seq_discarded", mlog.size(), 32'd0);

      // drain_done with two entries
      #1 mem_req_rdy = 1'b0;
      txn(1'b1, 32'h700, 32'd10, 8'h51, r, ac, rc, mv, mm);
      txn(1'b1, 32'h704, 32'd11, 8'h52, r, ac, rc, mv, mm);
      @(posedge clk); #1 drain = 1'b1;
      @(negedge clk);
      check("dd_low_nonempty", {31'd0, drain_done}, 32'd0);
      @(posedge clk); #1 mem_req_rdy = 1'b1;
      pulses = 0; pulse_c = -1; last_pop = -1;
      repeat (10) begin
         @(negedge clk);
         if (mem_req_val && mem_req_rdy) last_pop = cyc;
         if (drain_done) begin
            pulses++;
            pulse_c = cyc;
         end
      end
      check("dd_pulse_count", pulses, 32'd1);
      check("dd_pulse_cycle", pulse_c, last_pop + 1);
      // re-arm: drop drain, raise again with an empty buffer
      @(posedge clk); #1 drain = 1'b0;
      @(posedge clk); #1 drain = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (drain_done) pulses++;
      end
      check("dd_rearm_count", pulses, 32'd1);
      @(posedge clk); #1 drain = 1'b0;

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
